base_fifo_sync_pkt: RTL and testbench

Single-clock, parametrised FIFO that generalises our 16x9 FWFT FIFO wrapper to any power-of-two depth and any data width. It supports both standard and first-word-fall-through read modes. It adds an optional packet mode: written words stay invisible to the reader until the writer commits them, and the writer can discard them to roll back. It sits between packet producers and consumers that share one clock domain, for example a command assembler feeding a bus engine.

---
 rtl/base_fifo_sync_pkt.sv | 162 ++++++++++++++++
 tb/tb_base_fifo_sync_pkt.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/base_fifo_sync_pkt.sv
// -----------------------------------------------------------------------------
// base_fifo_sync_pkt
//
// Single-clock FIFO of any power-of-two depth and any data width, with standard
// or first-word-fall-through (FWFT) read mode. Optional packet mode holds
// written words back from the reader until Commit, or rolls them back on
// Discard.
//
// Three CW-bit pointers, the top bit of each being the wrap bit:
//   wr : speculative write pointer (next free entry)
//   cm : commit pointer (end of the words the reader may see)
//   rd : read pointer (head entry; in FWFT mode the head shown on Dout keeps
//        its entry until it is consumed)
//
// Handshake semantics:
//   A write is accepted when Write=1 and Full=0. Both are sampled at the same
//   rising edge and Full is the registered value from before that edge, so a
//   simultaneous read never makes room for a write to a full FIFO. A rejected
//   write pulses Overflow for one cycle.
//   Standard mode: Read=1 with committed data available loads Dout and pulses
//   Valid on the next cycle; otherwise Underflow pulses and Valid=0.
//   FWFT mode: Valid=1 means Dout is the head word; Read=1 while Valid=1
//   consumes it, Read=1 while Valid=0 pulses Underflow.
//
// Ports:
//   Clk, ResetN           clock, synchronous active-low reset
//   Din, Write            write data and request
//   Commit, Discard       publish / drop uncommitted words (packet mode only)
//   Read                  read request (standard) or acknowledge (FWFT)
//   Dout, Valid           read data and its qualifier
//   Empty, Full           no readable word / occupancy equals Depth
//   ProgFull, ProgEmpty   programmable thresholds on WrDataCount / RdDataCount
//   WrDataCount           committed plus uncommitted words held
//   RdDataCount           committed words not yet consumed
//   Overflow, Underflow   one-cycle pulses for a rejected write / read
// -----------------------------------------------------------------------------
module base_fifo_sync_pkt #(
   parameter int Width          = 9,
   parameter int Depth          = 16,
   parameter int FirstWordFall  = 1,
   parameter int PacketMode     = 0,
   parameter int ProgFullValue  = 12,
   parameter int ProgEmptyValue = 5,
   localparam int CW            = $clog2(Depth) + 1
) (
   input  logic             Clk,
   input  logic             ResetN,
   input  logic [Width-1:0] Din,
   input  logic             Write,
   input  logic             Commit,
   input  logic             Discard,
   input  logic             Read,
   output logic [Width-1:0] Dout,
   output logic             Valid,
   output logic             Empty,
   output logic             Full,
   output logic             ProgFull,
   output logic             ProgEmpty,
   output logic [CW-1:0]    WrDataCount,
   output logic [CW-1:0]    RdDataCount,
   output logic             Overflow,
   output logic             Underflow
);

   localparam int AW = CW - 1;
   localparam logic [CW-1:0] DEPTH_C  = CW'(Depth);
   localparam logic [CW-1:0] PFULL_C  = CW'(ProgFullValue);
   localparam logic [CW-1:0] PEMPTY_C = CW'(ProgEmptyValue);

   logic [Width-1:0] mem [Depth];

   logic [CW-1:0] wr, cm, rd;
   logic [CW-1:0] wr_n, cm_n, rd_n;
   logic [CW-1:0] rd_avail;
   logic [CW-1:0] wr_cnt_n, rd_cnt_n;
   logic [AW-1:0] rd_idx;
   logic          wr_ok, wr_keep, do_commit, do_discard;
   logic          rd_ok, rd_fail, load, valid_n;

   always_comb begin
      rd_avail   = cm - rd;
      do_discard = (PacketMode != 0) && Discard;
      do_commit  = (PacketMode != 0) && Commit && !Discard;
      wr_ok      = Write && !Full;
      // A write landing in the same cycle as Discard belongs to the dropped packet.
      wr_keep    = wr_ok && !do_discard;

      if (FirstWordFall != 0) begin
         rd_ok   = Read && Valid;
         rd_fail = Read && !Valid;
      end else begin
         rd_ok   = Read && (rd_avail != '0);
         rd_fail = Read && (rd_avail == '0);
      end

      wr_n = do_discard ? cm : wr + CW'(wr_keep);
      cm_n = ((PacketMode == 0) || do_commit) ? wr_n : cm;
      rd_n = rd + CW'(rd_ok);

      wr_cnt_n = wr_n - rd_n;
      rd_cnt_n = cm_n - rd_n;

      if (FirstWordFall != 0) begin
         // The output register refills whenever it is empty or being consumed.
         // Only words committed before this edge (cm, not cm_n) may be shown,
         // which gives the one-cycle write-to-visibility delay.
         rd_idx = rd_n[AW-1:0];
         if (!Valid || Read) begin
            load    = (cm - rd_n) != '0;
            valid_n = load;
         end else begin
            load    = 1'b0;
            valid_n = 1'b1;
         end
      end else begin
         rd_idx  = rd[AW-1:0];
         load    = rd_ok;
         valid_n = rd_ok;
      end
   end

   always_ff @(posedge Clk) begin
      if (ResetN && wr_keep) begin
         mem[wr[AW-1:0]] <= Din;
      end
   end

   always_ff @(posedge Clk) begin
      if (!ResetN) begin
         wr          <= '0;
         cm          <= '0;
         rd          <= '0;
         Dout        <= '0;
         Valid       <= 1'b0;
         Empty       <= 1'b1;
         Full        <= 1'b0;
         ProgFull    <= 1'b0;
         ProgEmpty   <= 1'b1;
         WrDataCount <= '0;
         RdDataCount <= '0;
         Overflow    <= 1'b0;
         Underflow   <= 1'b0;
      end else begin
         wr          <= wr_n;
         cm          <= cm_n;
         rd          <= rd_n;
         if (load) begin
            Dout <= mem[rd_idx];
         end
         Valid       <= valid_n;
         Empty       <= (FirstWordFall != 0) ? !valid_n : (rd_cnt_n == '0);
         Full        <= wr_cnt_n == DEPTH_C;
         ProgFull    <= wr_cnt_n >= PFULL_C;
         ProgEmpty   <= rd_cnt_n <= PEMPTY_C;
         WrDataCount <= wr_cnt_n;
         RdDataCount <= rd_cnt_n;
         Overflow    <= Write && Full;
         Underflow   <= rd_fail;
      end
   end

endmodule

// File: tb/tb_base_fifo_sync_pkt.sv
// -----------------------------------------------------------------------------
// tb_base_fifo_sync_pkt
//
// Four instances share one set of inputs; each test resets them all and then
// examines the instance whose configuration it targets:
//   u_fw : Width 9, Depth 16, FWFT, streaming
//   u_st : Width 9, Depth 16, standard read mode, streaming
//   u_pk : Width 9, Depth 16, FWFT, packet mode
//   u_d4 : Width 9, Depth 4, FWFT, streaming (pointer wrap)
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
// -----------------------------------------------------------------------------
module tb_base_fifo_sync_pkt;

   logic       Clk = 1'b0;
   logic       ResetN = 1'b0;
   logic [8:0] Din = '0;
   logic       Write = 1'b0, Commit = 1'b0, Discard = 1'b0, Read = 1'b0;

   logic [8:0] fw_dout, st_dout, pk_dout, d4_dout;
   logic       fw_valid, fw_empty, fw_full, fw_pfull, fw_pempty, fw_ovf, fw_unf;
   logic       st_valid, st_empty, st_full, st_pfull, st_pempty, st_ovf, st_unf;
   logic       pk_valid, pk_empty, pk_full, pk_pfull, pk_pempty, pk_ovf, pk_unf;
   logic       d4_valid, d4_empty, d4_full, d4_pfull, d4_pempty, d4_ovf, d4_unf;
   logic [4:0] fw_wcnt, fw_rcnt, st_wcnt, st_rcnt, pk_wcnt, pk_rcnt;
   logic [2:0] d4_wcnt, d4_rcnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 Clk = ~Clk;

   base_fifo_sync_pkt u_fw (
      .Clk(Clk), .ResetN(ResetN), .Din(Din), .Write(Write), .Commit(Commit),
      .Discard(Discard), .Read(Read), .Dout(fw_dout), .Valid(fw_valid),
      .Empty(fw_empty), .Full(fw_full), .ProgFull(fw_pfull), .ProgEmpty(fw_pempty),
      .WrDataCount(fw_wcnt), .RdDataCount(fw_rcnt), .Overflow(fw_ovf), .Underflow(fw_unf));

   base_fifo_sync_pkt #(.FirstWordFall(0)) u_st (
      .Clk(Clk), .ResetN(ResetN), .Din(Din), .Write(Write), .Commit(Commit),
      .Discard(Discard), .Read(Read), .Dout(st_dout), .Valid(st_valid),
      .Empty(st_empty), .Full(st_full), .ProgFull(st_pfull), .ProgEmpty(st_pempty),
      .WrDataCount(st_wcnt), .RdDataCount(st_rcnt), .Overflow(st_ovf), .Underflow(st_unf));

   base_fifo_sync_pkt #(.PacketMode(1)) u_pk (
      .Clk(Clk), .ResetN(ResetN), .Din(Din), .Write(Write), .Commit(Commit),
      .Discard(Discard), .Read(Read), .Dout(pk_dout), .Valid(pk_valid),
      .Empty(pk_empty), .Full(pk_full), .ProgFull(pk_pfull), .ProgEmpty(pk_pempty),
      .WrDataCount(pk_wcnt), .RdDataCount(pk_rcnt), .Overflow(pk_ovf), .Underflow(pk_unf));

   base_fifo_sync_pkt #(.Depth(4), .ProgFullValue(3), .ProgEmptyValue(1)) u_d4 (
      .Clk(Clk), .ResetN(ResetN), .Din(Din), .Write(Write), .Commit(Commit),
      .Discard(Discard), .Read(Read), .Dout(d4_dout), .Valid(d4_valid),
      .Empty(d4_empty), .Full(d4_full), .ProgFull(d4_pfull), .ProgEmpty(d4_pempty),
      .WrDataCount(d4_wcnt), .RdDataCount(d4_rcnt), .Overflow(d4_ovf), .Underflow(d4_unf));

   // Reset value of {Dout, Valid, Empty, Full, ProgFull, ProgEmpty, Overflow, Underflow}
   localparam logic [15:0] RST_FLAGS = {9'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

   task automatic step;
      @(posedge Clk);
      #1;
   endtask

   task automatic idle_inputs;
      Write = 1'b0; Read = 1'b0; Commit = 1'b0; Discard = 1'b0; Din = '0;
   endtask

   task automatic do_reset;
      idle_inputs();
      ResetN = 1'b0;
      step();
      step();
      ResetN = 1'b1;
   endtask

   task automatic test_reset;
      do_reset();
      n_checks++; if (fw_dout !== 9'h000) begin n_fail++; $display("FAIL reset_dout got=%0h exp=0", fw_dout); end
      n_checks++; if (fw_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b exp=0", fw_valid); end
      n_checks++; if (fw_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%0b exp=1", fw_empty); end
      n_checks++; if (fw_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%0b exp=0", fw_full); end
      n_checks++; if (fw_pempty !== 1'b1) begin n_fail++; $display("FAIL reset_pempty got=%0b exp=1", fw_pempty); end
      n_checks++; if (fw_pfull !== 1'b0) begin n_fail++; $display("FAIL reset_pfull got=%0b exp=0", fw_pfull); end
      n_checks++; if ({fw_wcnt, fw_rcnt} !== 10'd0) begin n_fail++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", fw_wcnt, fw_rcnt); end
      n_checks++; if ({fw_ovf, fw_unf} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses got=%0b%0b exp=00", fw_ovf, fw_unf); end
      n_checks++; if ({st_dout, st_valid, st_empty, st_full, st_pfull, st_pempty, st_ovf, st_unf, st_wcnt, st_rcnt} !== {RST_FLAGS, 10'd0})
         begin n_fail++; $display("FAIL reset_st got=%0h exp=%0h", {st_dout, st_valid, st_empty, st_full, st_pfull, st_pempty, st_ovf, st_unf, st_wcnt, st_rcnt}, {RST_FLAGS, 10'd0}); end
      n_checks++; if ({d4_dout, d4_valid, d4_empty, d4_full, d4_pfull, d4_pempty, d4_ovf, d4_unf, d4_wcnt, d4_rcnt} !== {RST_FLAGS, 6'd0})
         begin n_fail++; $display("FAIL reset_d4 got=%0h exp=%0h", {d4_dout, d4_valid, d4_empty, d4_full, d4_pfull, d4_pempty, d4_ovf, d4_unf, d4_wcnt, d4_rcnt}, {RST_FLAGS, 6'd0}); end
   endtask

   task automatic test_fill;
      do_reset();
      for (int i = 1; i <= 16; i++) begin
         Din = 9'(i); Write = 1'b1;
         step();
         n_checks++; if (fw_wcnt !== 5'(i)) begin n_fail++; $display("FAIL fill_wcnt[%0d] got=%0d exp=%0d", i, fw_wcnt, i); end
         n_checks++; if (fw_pfull !== (i >= 12)) begin n_fail++; $display("FAIL fill_pfull[%0d] got=%0b exp=%0b", i, fw_pfull, i >= 12); end
         n_checks++; if (fw_full !== (i == 16)) begin n_fail++; $display("FAIL fill_full[%0d] got=%0b exp=%0b", i, fw_full, i == 16); end
      end
      Din = 9'h1FF;
      step();
      Write = 1'b0;
      n_checks++; if (fw_ovf !== 1'b1) begin n_fail++; $display("FAIL fill_overflow got=%0b exp=1", fw_ovf); end
      n_checks++; if (fw_wcnt !== 5'd16) begin n_fail++; $display("FAIL fill_wcnt_after_ovf got=%0d exp=16", fw_wcnt); end
      n_checks++; if (fw_dout !== 9'h001) begin n_fail++; $display("FAIL fill_head got=%0h exp=1", fw_dout); end
      step();
      n_checks++; if (fw_ovf !== 1'b0) begin n_fail++; $display("FAIL fill_ovf_pulse got=%0b exp=0", fw_ovf); end
   endtask

   // Continues from the full FIFO left by test_fill.
   task automatic test_fwft_drain;
      Read = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         n_checks++; if (fw_dout !== 9'(i) || fw_valid !== 1'b1) begin n_fail++; $display("FAIL drain_dout[%0d] got=%0h/%0b exp=%0h/1", i, fw_dout, fw_valid, i); end
         step();
         n_checks++; if (fw_rcnt !== 5'(16 - i)) begin n_fail++; $display("FAIL drain_rcnt[%0d] got=%0d exp=%0d", i, fw_rcnt, 16 - i); end
         n_checks++; if (fw_pempty !== (16 - i <= 5)) begin n_fail++; $display("FAIL drain_pempty[%0d] got=%0b exp=%0b", i, fw_pempty, 16 - i <= 5); end
      end
      n_checks++; if (fw_empty !== 1'b1 || fw_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got=%0b/%0b exp=1/0", fw_empty, fw_valid); end
      step();
      Read = 1'b0;
      n_checks++; if (fw_unf !== 1'b1) begin n_fail++; $display("FAIL drain_underflow got=%0b exp=1", fw_unf); end
      step();
      n_checks++; if (fw_unf !== 1'b0) begin n_fail++; $display("FAIL drain_unf_pulse got=%0b exp=0", fw_unf); end
   endtask

   task automatic test_standard;
      do_reset();
      Din = 9'h0A5; Write = 1'b1;
      step();
      Write = 1'b0;
      n_checks++; if (st_valid !== 1'b0 || st_empty !== 1'b0) begin n_fail++; $display("FAIL std_after_write got=%0b/%0b exp=0/0", st_valid, st_empty); end
      n_checks++; if (st_rcnt !== 5'd1) begin n_fail++; $display("FAIL std_rcnt got=%0d exp=1", st_rcnt); end
      Read = 1'b1;
      step();
      n_checks++; if (st_dout !== 9'h0A5 || st_valid !== 1'b1) begin n_fail++; $display("FAIL std_read got=%0h/%0b exp=a5/1", st_dout, st_valid); end
      n_checks++; if (st_unf !== 1'b0 || st_empty !== 1'b1) begin n_fail++; $display("FAIL std_read_flags got=%0b/%0b exp=0/1", st_unf, st_empty); end
      step();
      Read = 1'b0;
      n_checks++; if (st_unf !== 1'b1 || st_valid !== 1'b0) begin n_fail++; $display("FAIL std_underflow got=%0b/%0b exp=1/0", st_unf, st_valid); end
      n_checks++; if (st_dout !== 9'h0A5) begin n_fail++; $display("FAIL std_dout_hold got=%0h exp=a5", st_dout); end
      step();
   endtask

   task automatic test_packet;
      logic [8:0] exp_words [5];
      exp_words = '{9'h011, 9'h012, 9'h013, 9'h014, 9'h019};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         Din = 9'h011 + 9'(i); Write = 1'b1;
         step();
      end
      Write = 1'b0;
      step();
      n_checks++; if (pk_rcnt !== 5'd0 || pk_wcnt !== 5'd3) begin n_fail++; $display("FAIL pkt_uncommitted got=%0d/%0d exp=0/3", pk_rcnt, pk_wcnt); end
      n_checks++; if (pk_empty !== 1'b1 || pk_valid !== 1'b0) begin n_fail++; $display("FAIL pkt_hidden got=%0b/%0b exp=1/0", pk_empty, pk_valid); end
      Din = 9'h014; Write = 1'b1; Commit = 1'b1;
      step();
      Write = 1'b0; Commit = 1'b0;
      n_checks++; if (pk_rcnt !== 5'd4 || pk_wcnt !== 5'd4) begin n_fail++; $display("FAIL pkt_commit got=%0d/%0d exp=4/4", pk_rcnt, pk_wcnt); end
      step();
      n_checks++; if (pk_valid !== 1'b1 || pk_dout !== 9'h011) begin n_fail++; $display("FAIL pkt_visible got=%0b/%0h exp=1/11", pk_valid, pk_dout); end
      for (int i = 0; i < 2; i++) begin
         Din = 9'h015 + 9'(i); Write = 1'b1;
         step();
      end
      Write = 1'b0;
      n_checks++; if (pk_wcnt !== 5'd6 || pk_rcnt !== 5'd4) begin n_fail++; $display("FAIL pkt_second got=%0d/%0d exp=6/4", pk_wcnt, pk_rcnt); end
      Discard = 1'b1;
      step();
      Discard = 1'b0;
      n_checks++; if (pk_wcnt !== 5'd4 || pk_rcnt !== 5'd4) begin n_fail++; $display("FAIL pkt_discard got=%0d/%0d exp=4/4", pk_wcnt, pk_rcnt); end
      Din = 9'h017; Write = 1'b1;
      step();
      Write = 1'b0; Commit = 1'b1; Discard = 1'b1;
      step();
      Commit = 1'b0; Discard = 1'b0;
      n_checks++; if (pk_wcnt !== 5'd4 || pk_rcnt !== 5'd4) begin n_fail++; $display("FAIL pkt_commit_discard got=%0d/%0d exp=4/4", pk_wcnt, pk_rcnt); end
      Din = 9'h018; Write = 1'b1; Discard = 1'b1;
      step();
      Discard = 1'b0;
      n_checks++; if (pk_wcnt !== 5'd4) begin n_fail++; $display("FAIL pkt_write_discard got=%0d exp=4", pk_wcnt); end
      Din = 9'h019; Commit = 1'b1;
      step();
      Write = 1'b0; Commit = 1'b0;
      n_checks++; if (pk_wcnt !== 5'd5 || pk_rcnt !== 5'd5) begin n_fail++; $display("FAIL pkt_recommit got=%0d/%0d exp=5/5", pk_wcnt, pk_rcnt); end
      Read = 1'b1;
      for (int i = 0; i < 5; i++) begin
         n_checks++; if (pk_dout !== exp_words[i] || pk_valid !== 1'b1) begin n_fail++; $display("FAIL pkt_drain[%0d] got=%0h/%0b exp=%0h/1", i, pk_dout, pk_valid, exp_words[i]); end
         step();
      end
      Read = 1'b0;
      n_checks++; if (pk_valid !== 1'b0 || pk_empty !== 1'b1 || pk_rcnt !== 5'd0) begin n_fail++; $display("FAIL pkt_drained got=%0b/%0b/%0d exp=0/1/0", pk_valid, pk_empty, pk_rcnt); end
   endtask

   task automatic test_full_rw;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         Din = 9'h020 + 9'(i); Write = 1'b1;
         step();
      end
      n_checks++; if (fw_full !== 1'b1 || fw_dout !== 9'h020) begin n_fail++; $display("FAIL full_rw_pre got=%0b/%0h exp=1/20", fw_full, fw_dout); end
      Din = 9'h1AA; Read = 1'b1;
      step();
      Write = 1'b0; Read = 1'b0;
      n_checks++; if (fw_ovf !== 1'b1) begin n_fail++; $display("FAIL full_rw_ovf got=%0b exp=1", fw_ovf); end
      n_checks++; if (fw_wcnt !== 5'd15 || fw_full !== 1'b0) begin n_fail++; $display("FAIL full_rw_count got=%0d/%0b exp=15/0", fw_wcnt, fw_full); end
      n_checks++; if (fw_dout !== 9'h021) begin n_fail++; $display("FAIL full_rw_read got=%0h exp=21", fw_dout); end
   endtask

   task automatic test_reset_mid_packet;
      do_reset();
      Din = 9'h031; Write = 1'b1; Commit = 1'b1;
      step();
      Din = 9'h032; Commit = 1'b0;
      step();
      Write = 1'b0;
      step();
      n_checks++; if (pk_valid !== 1'b1 || pk_wcnt !== 5'd2) begin n_fail++; $display("FAIL midpkt_pre got=%0b/%0d exp=1/2", pk_valid, pk_wcnt); end
      ResetN = 1'b0; Din = 9'h033; Write = 1'b1; Commit = 1'b1; Read = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         n_checks++; if ({pk_dout, pk_valid, pk_empty, pk_full, pk_pfull, pk_pempty, pk_ovf, pk_unf, pk_wcnt, pk_rcnt} !== {RST_FLAGS, 10'd0})
            begin n_fail++; $display("FAIL midpkt_reset[%0d] got=%0h exp=%0h", i, {pk_dout, pk_valid, pk_empty, pk_full, pk_pfull, pk_pempty, pk_ovf, pk_unf, pk_wcnt, pk_rcnt}, {RST_FLAGS, 10'd0}); end
      end
      ResetN = 1'b1;
      idle_inputs();
      step();
      n_checks++; if (pk_valid !== 1'b0 || pk_wcnt !== 5'd0 || pk_rcnt !== 5'd0) begin n_fail++; $display("FAIL midpkt_after got=%0b/%0d/%0d exp=0/0/0", pk_valid, pk_wcnt, pk_rcnt); end
   endtask

   // Scoreboard for the Depth=4 FWFT instance. The model holds every accepted
   // word; the head is shown one cycle after it exists and stays until read.
   task automatic test_wrap_random;
      logic [8:0] exp_q[$];
      logic       vm, vm_n, w, r, of, uf;
      logic [8:0] d;
      int         cnt;
      do_reset();
      vm = 1'b0;
      for (int i = 0; i < 100; i++) begin
         w = ($urandom_range(0, 3) != 0);
         r = 1'($urandom_range(0, 1));
         d = 9'($urandom_range(0, 511));
         Write = w; Read = r; Din = d;
         cnt  = exp_q.size();
         of   = w && (cnt == 4);
         uf   = r && !vm;
         vm_n = (vm && r) ? (cnt >= 2) : (cnt >= 1);
         if (vm && r) void'(exp_q.pop_front());
         if (w && cnt < 4) exp_q.push_back(d);
         step();
         vm = vm_n;
         n_checks++; if (d4_valid !== vm) begin n_fail++; $display("FAIL wrap_valid[%0d] got=%0b exp=%0b", i, d4_valid, vm); end
         if (vm) begin
            n_checks++; if (d4_dout !== exp_q[0]) begin n_fail++; $display("FAIL wrap_dout[%0d] got=%0h exp=%0h", i, d4_dout, exp_q[0]); end
         end
         n_checks++; if (d4_wcnt !== 3'(exp_q.size())) begin n_fail++; $display("FAIL wrap_wcnt[%0d] got=%0d exp=%0d", i, d4_wcnt, exp_q.size()); end
         n_checks++; if (d4_full !== (exp_q.size() == 4)) begin n_fail++; $display("FAIL wrap_full[%0d] got=%0b exp=%0b", i, d4_full, exp_q.size() == 4); end
         n_checks++; if (d4_ovf !== of || d4_unf !== uf) begin n_fail++; $display("FAIL wrap_pulses[%0d] got=%0b%0b exp=%0b%0b", i, d4_ovf, d4_unf, of, uf); end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_fill();
      test_fwft_drain();
      test_standard();
      test_packet();
      test_full_rw();
      test_reset_mid_packet();
      test_wrap_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
